// File: rtl/pwm_pkg.sv
// Shared types for the PWM fade sequencer: FSM state encoding and channel control word layout.
package pwm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StFin
    } pwm_state_e;

    localparam int unsigned CtrlAlign = 2;
    localparam int unsigned CtrlPol   = 1;
    localparam int unsigned CtrlEn    = 0;

    typedef struct packed {
        logic align;
        logic pol;
        logic en;
    } pwm_ctrl_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Counts PWM periods (pcnt) and periods-per-step (hcnt); step_tick marks the last clock of a hold window.
module pwm_period_timer #(
    parameter int unsigned DW = 32,
    parameter int unsigned HW = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic [DW-1:0] period,
    input  logic [HW-1:0] hold,
    output logic          step_tick
);

    logic [DW-1:0] pcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          pwrap;
    logic          hwrap;

    // period and hold are never zero here; the caller substitutes 1.
    always_comb begin
        pwrap     = (pcnt_q == period - DW'(1));
        hwrap     = (hcnt_q == hold - HW'(1));
        step_tick = !clear && pwrap && hwrap;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pcnt_q <= '0;
            hcnt_q <= '0;
        end else if (clear) begin
            pcnt_q <= '0;
            hcnt_q <= '0;
        end else if (pwrap) begin
            pcnt_q <= '0;
            hcnt_q <= hwrap ? '0 : hcnt_q + HW'(1);
        end else begin
            pcnt_q <= pcnt_q + DW'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Drives one pwmchannel's write ports through a linear duty ramp.
// Define PWM_FADE_LOOP_EN for endless ping-pong between the two endpoints.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned HW = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] cfg_period,
    input  logic [DW-1:0] cfg_start_duty,
    input  logic [DW-1:0] cfg_end_duty,
    input  logic [DW-1:0] cfg_step,
    input  logic [HW-1:0] cfg_hold,
    input  logic [2:0]    cfg_control,
    output logic          period_wen,
    output logic [DW-1:0] period_out,
    output logic          duty_wen,
    output logic [DW-1:0] duty_out,
    output logic          cont_wen,
    output logic [2:0]    control_out,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    pwm_state_e    state_q;
    logic [DW-1:0] period_q, start_q, end_q, step_q, cur_q;
    logic [HW-1:0] hold_q;
    logic          at_end_q;
    logic          period_wen_q, duty_wen_q, cont_wen_q, busy_q, done_q, cfg_err_q;
    logic [DW-1:0] period_out_q, duty_out_q;
    pwm_ctrl_t     control_q;

    logic          step_tick;
    logic          timer_clear;
    logic          do_step;
    logic [DW:0]   up_sum;
    logic [DW:0]   dn_lim;
    logic [DW-1:0] next_duty;

    assign timer_clear = !(state_q == StLoad || state_q == StRun);

    pwm_period_timer #(
        .DW(DW),
        .HW(HW)
    ) u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (timer_clear),
        .period   (period_q),
        .hold     (hold_q),
        .step_tick(step_tick)
    );

    // Saturating step towards end_q, one bit wider so neither direction can wrap.
    always_comb begin
        up_sum    = {1'b0, cur_q} + {1'b0, step_q};
        dn_lim    = {1'b0, end_q} + {1'b0, step_q};
        next_duty = end_q;
        if (end_q >= start_q) begin
            if (up_sum < {1'b0, end_q}) next_duty = up_sum[DW-1:0];
        end else begin
            if ({1'b0, cur_q} > dn_lim) next_duty = cur_q - step_q;
        end
    end

    // Timer is cleared in IDLE and counts from LOAD, so the first step lands period*hold later.
    assign do_step = step_tick && !at_end_q &&
                     ((state_q == StLoad && start_q != end_q) || state_q == StRun);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            period_q     <= '0;
            start_q      <= '0;
            end_q        <= '0;
            step_q       <= '0;
            hold_q       <= '0;
            cur_q        <= '0;
            at_end_q     <= 1'b0;
            period_wen_q <= 1'b0;
            duty_wen_q   <= 1'b0;
            cont_wen_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            period_out_q <= '0;
            duty_out_q   <= '0;
            control_q    <= '0;
        end else begin
            period_wen_q <= 1'b0;
            duty_wen_q   <= 1'b0;
            cont_wen_q   <= 1'b0;
            done_q       <= 1'b0;
            if (abort && state_q != StIdle) begin
                cont_wen_q   <= 1'b1;
                control_q.en <= 1'b0;
                busy_q       <= 1'b0;
                at_end_q     <= 1'b0;
                state_q      <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            if (cfg_period == '0) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                cfg_err_q       <= 1'b0;
                                period_q        <= cfg_period;
                                start_q         <= cfg_start_duty;
                                end_q           <= cfg_end_duty;
                                step_q          <= (cfg_step == '0) ? DW'(1) : cfg_step;
                                hold_q          <= (cfg_hold == '0) ? HW'(1) : cfg_hold;
                                cur_q           <= cfg_start_duty;
                                period_wen_q    <= 1'b1;
                                duty_wen_q      <= 1'b1;
                                cont_wen_q      <= 1'b1;
                                period_out_q    <= cfg_period;
                                duty_out_q      <= cfg_start_duty;
                                control_q.align <= cfg_control[CtrlAlign];
                                control_q.pol   <= cfg_control[CtrlPol];
                                control_q.en    <= cfg_control[CtrlEn];
                                busy_q          <= 1'b1;
                                state_q         <= StLoad;
                            end
                        end
                    end
                    StLoad: begin
                        if (start_q == end_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StFin;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (at_end_q) begin
                            at_end_q <= 1'b0;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= StFin;
                        end
                    end
                    StFin: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase

                if (do_step) begin
                    duty_wen_q <= 1'b1;
                    duty_out_q <= next_duty;
                    cur_q      <= next_duty;
                    if (next_duty == end_q) begin
`ifdef PWM_FADE_LOOP_EN
                        start_q <= end_q;
                        end_q   <= start_q;
`else
                        at_end_q <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    assign period_wen  = period_wen_q;
    assign period_out  = period_out_q;
    assign duty_wen    = duty_wen_q;
    assign duty_out    = duty_out_q;
    assign cont_wen    = cont_wen_q;
    assign control_out = control_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: a ramp model queues expected channel writes; a monitor checks them.
module tb_pwm_fade_ctrl;

    localparam int DW = 32;
    localparam int HW = 16;

    logic          tb_clk = 1'b0;
    logic          n_rst;
    logic          start, abort;
    logic [DW-1:0] cfg_period, cfg_start_duty, cfg_end_duty, cfg_step;
    logic [HW-1:0] cfg_hold;
    logic [2:0]    cfg_control;
    logic          period_wen, duty_wen, cont_wen, busy, done, cfg_err;
    logic [DW-1:0] period_out, duty_out;
    logic [2:0]    control_out;

    pwm_fade_ctrl #(.DW(DW), .HW(HW)) dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .start         (start),
        .abort         (abort),
        .cfg_period    (cfg_period),
        .cfg_start_duty(cfg_start_duty),
        .cfg_end_duty  (cfg_end_duty),
        .cfg_step      (cfg_step),
        .cfg_hold      (cfg_hold),
        .cfg_control   (cfg_control),
        .period_wen    (period_wen),
        .period_out    (period_out),
        .duty_wen      (duty_wen),
        .duty_out      (duty_out),
        .cont_wen      (cont_wen),
        .control_out   (control_out),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          pw, dw, cw, dn, bz;
        logic [DW-1:0] per, duty;
        logic [2:0]    ctl;
    } ev_t;

    ev_t sb[$];
    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 0;

    function automatic ev_t mk_ev(int c, logic pw, logic dw, logic cw, logic dn, logic bz,
                                  logic [DW-1:0] per, logic [DW-1:0] duty, logic [2:0] ctl);
        ev_t e;
        e.cyc = c; e.pw = pw; e.dw = dw; e.cw = cw; e.dn = dn; e.bz = bz;
        e.per = per; e.duty = duty; e.ctl = ctl;
        return e;
    endfunction

    ev_t mexp;
    always @(negedge tb_clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mexp = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event want cyc=%0d dw=%b duty=%0d done=%b cw=%b",
                         mexp.cyc, mexp.dw, mexp.duty, mexp.dn, mexp.cw);
            end
            if (period_wen || duty_wen || cont_wen || done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d pw=%b dw=%b cw=%b done=%b duty=%0d",
                             cyc, period_wen, duty_wen, cont_wen, done, duty_out);
                end else begin
                    mexp = sb.pop_front();
                    if (mexp.cyc != cyc || mexp.pw != period_wen || mexp.dw != duty_wen ||
                        mexp.cw != cont_wen || mexp.dn != done || mexp.bz != busy ||
                        mexp.per != period_out || mexp.duty != duty_out ||
                        mexp.ctl != control_out || cfg_err != 1'b0) begin
                        errors++;
                        $display({"FAIL event got cyc=%0d pw=%b dw=%b cw=%b dn=%b busy=%b ",
                                  "per=%0d duty=%0d ctl=%b err=%b; want cyc=%0d pw=%b dw=%b ",
                                  "cw=%b dn=%b busy=%b per=%0d duty=%0d ctl=%b err=0"},
                                 cyc, period_wen, duty_wen, cont_wen, done, busy, period_out,
                                 duty_out, control_out, cfg_err, mexp.cyc, mexp.pw, mexp.dw,
                                 mexp.cw, mexp.dn, mexp.bz, mexp.per, mexp.duty, mexp.ctl);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic scramble_cfg();
        cfg_period     = DW'($urandom_range(0, 40));
        cfg_start_duty = DW'($urandom);
        cfg_end_duty   = DW'($urandom);
        cfg_step       = DW'($urandom_range(0, 9));
        cfg_hold       = HW'($urandom_range(0, 3));
        cfg_control    = 3'($urandom);
    endtask

    // Issue one fade and queue everything the channel should see, from the ramp rules.
    task automatic run_fade(input int p, input int s, input int e, input int st, input int h,
                            input logic [2:0] ctl, input int ab_off, input bit busy_start);
        ev_t           evs[$];
        int            l, a, t, cur, cs, ce, nxt, stp, hh, end_cyc, last;
        logic [DW-1:0] held;
        stp = (st == 0) ? 1 : st;
        hh  = (h == 0) ? 1 : h;
`ifdef PWM_FADE_LOOP_EN
        if (ab_off == 0 && s != e) ab_off = 4 * p * hh + 1;
`endif
        cfg_period = DW'(p); cfg_start_duty = DW'(s); cfg_end_duty = DW'(e);
        cfg_step = DW'(st); cfg_hold = HW'(h); cfg_control = ctl;
        start = 1'b1;
        l = cyc + 1;
        a = (ab_off == 0) ? 0 : l + ab_off;
        evs.push_back(mk_ev(l, 1, 1, 1, 0, 1, DW'(p), DW'(s), ctl));
        end_cyc = l + 1;
        if (s == e) begin
            evs.push_back(mk_ev(l + 1, 0, 0, 0, 1, 0, DW'(p), DW'(s), ctl));
        end else begin
            t = l; cur = s; cs = s; ce = e; end_cyc = 1 << 30;
            forever begin
                t += p * hh;
                if ((a != 0 && t > a) || t > l + 40000) break;
                if (ce >= cs) nxt = (cur + stp >= ce) ? ce : cur + stp;
                else          nxt = (cur <= ce + stp) ? ce : cur - stp;
                evs.push_back(mk_ev(t, 0, 1, 0, 0, 1, DW'(p), DW'(nxt), ctl));
                cur = nxt;
                if (cur == ce) begin
`ifdef PWM_FADE_LOOP_EN
                    ce = cs;
                    cs = cur;
`else
                    evs.push_back(mk_ev(t + 1, 0, 0, 0, 1, 0, DW'(p), DW'(cur), ctl));
                    end_cyc = t + 1;
                    break;
`endif
                end
            end
        end
        held = DW'(s);
        last = l;
        foreach (evs[i]) begin
            if (a == 0 || evs[i].cyc <= a) begin
                sb.push_back(evs[i]);
                if (evs[i].dw) held = evs[i].duty;
                last = evs[i].cyc;
            end
        end
        if (a != 0 && a <= end_cyc) begin
            sb.push_back(mk_ev(a + 1, 0, 0, 1, 0, 0, DW'(p), held, ctl & 3'b110));
            last = a + 1;
        end
        tick();
        start = 1'b0;
        scramble_cfg();
        if (busy_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (a != 0) begin
            while (cyc < a) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        while (cyc < last + 2) tick();
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_period = '0; cfg_start_duty = '0; cfg_end_duty = '0;
        cfg_step = '0; cfg_hold = '0; cfg_control = '0;
        repeat (3) tick();
        @(negedge tb_clk);
        check("reset_outputs", {period_wen, period_out, duty_wen, duty_out, cont_wen,
                                control_out, busy, done, cfg_err}, '0);
        n_rst = 1'b1;
        tick();
        @(negedge tb_clk);
        check("post_reset_idle", {period_wen, duty_wen, cont_wen, busy, done, cfg_err}, '0);
        mon_en = 1;
        tick();

        run_fade(16, 0, 8, 4, 1, 3'b001, 0, 0);
        run_fade(15, 10, 0, 3, 2, 3'b010, 0, 0);
        run_fade(7, 5, 5, 2, 1, 3'b001, 0, 0);
        run_fade(4, 0, 2, 0, 1, 3'b101, 0, 0);

        // Zero period is rejected without touching the channel.
        cfg_period = '0; cfg_start_duty = DW'(1); cfg_end_duty = DW'(9); cfg_control = 3'b001;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge tb_clk);
        check("cfg_err_set", {cfg_err, busy}, 2'b10);
        repeat (4) tick();
        check("cfg_err_sticky", cfg_err, 1'b1);
        run_fade(10, 3, 9, 2, 0, 3'b011, 0, 0);
        check("cfg_err_cleared", cfg_err, 1'b0);

        run_fade(16, 0, 100, 5, 1, 3'b111, 40, 1);

        // start and abort together in IDLE: nothing happens.
        cfg_period = DW'(5); cfg_start_duty = DW'(0); cfg_end_duty = DW'(4); cfg_control = 3'b001;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        @(negedge tb_clk);
        check("start_abort_idle_busy", busy, 1'b0);
        repeat (8) tick();

        run_fade(16, 0, 8, 4, 1, 3'b001, 16 * 5 + 3, 0);
        run_fade(1, 0, 3, 1, 1, 3'b001, 0, 0);

        for (int n = 0; n < 25; n++) begin
            run_fade($urandom_range(1, 8), $urandom_range(0, 30), $urandom_range(0, 30),
                     $urandom_range(0, 9), $urandom_range(0, 3), 3'($urandom),
                     ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 150),
                     1'($urandom_range(0, 1)));
        end

        repeat (5) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("idle_at_end", {busy, done}, 2'b00);

        // Asynchronous reset in the middle of a ramp.
        mon_en = 0;
        cfg_period = DW'(4); cfg_start_duty = DW'(0); cfg_end_duty = DW'(20);
        cfg_step = DW'(1); cfg_hold = HW'(1); cfg_control = 3'b011;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("busy_before_reset", busy, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check("async_reset_outputs", {period_wen, period_out, duty_wen, duty_out, cont_wen,
                                      control_out, busy, done, cfg_err}, '0);
        tick();
        n_rst = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
